// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - LEGv8 opcodes, ALU op encoding and decoded control bundle
package legv8_pkg;

    localparam int IMM_W = 64;

    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    typedef enum logic [2:0] {
        ALU_PASSB = 3'b000,
        ALU_ADD   = 3'b010,
        ALU_SUB   = 3'b011
    } alu_op_t;

    typedef struct packed {
        logic             reg2loc;
        logic             alu_src;
        logic             mem_to_reg;
        logic             reg_write;
        logic             mem_write;
        logic             mem_read;
        logic             br_cond;
        logic             br_uncond;
        alu_op_t          alu_op;
        logic [4:0]       rd;
        logic [4:0]       rn;
        logic [4:0]       rm;
        logic [IMM_W-1:0] imm;
        logic             illegal;
    } ctrl_bundle_t;

endpackage

// File: rtl/legv8_decoder.sv
// rtl/legv8_decoder.sv - combinational LEGv8 instruction decode into a control bundle
module legv8_decoder
    import legv8_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_bundle_t bundle
);

    logic [IMM_W-1:0] imm_b;
    logic [IMM_W-1:0] imm_cb;
    logic [IMM_W-1:0] imm_d;

    sign_extend #(.IN_W(26), .OUT_W(IMM_W)) u_sext_b  (.in(instr[25:0]),  .out(imm_b));
    sign_extend #(.IN_W(19), .OUT_W(IMM_W)) u_sext_cb (.in(instr[23:5]),  .out(imm_cb));
    sign_extend #(.IN_W(9),  .OUT_W(IMM_W)) u_sext_d  (.in(instr[20:12]), .out(imm_d));

    // Narrowest opcode field is tested first so wider fields cannot alias it.
    always_comb begin
        bundle    = '0;
        bundle.rd = instr[4:0];
        bundle.rn = instr[9:5];
        bundle.rm = instr[20:16];
        if (instr[31:26] == OP_B) begin
            bundle.br_uncond = 1'b1;
            bundle.imm       = imm_b;
        end else if (instr[31:24] == OP_CBZ) begin
            bundle.br_cond = 1'b1;
            bundle.alu_op  = ALU_PASSB;
            bundle.imm     = imm_cb;
        end else if (instr[31:22] == OP_ADDI) begin
            bundle.alu_src   = 1'b1;
            bundle.reg_write = 1'b1;
            bundle.alu_op    = ALU_ADD;
            bundle.imm       = {{(IMM_W-12){1'b0}}, instr[21:10]};
        end else begin
            case (instr[31:21])
                OP_ADD, OP_SUB: begin
                    bundle.reg2loc   = 1'b1;
                    bundle.reg_write = 1'b1;
                    bundle.alu_op    = (instr[31:21] == OP_SUB) ? ALU_SUB : ALU_ADD;
                end
                OP_LDUR: begin
                    bundle.alu_src    = 1'b1;
                    bundle.mem_to_reg = 1'b1;
                    bundle.reg_write  = 1'b1;
                    bundle.mem_read   = 1'b1;
                    bundle.alu_op     = ALU_ADD;
                    bundle.imm        = imm_d;
                end
                OP_STUR: begin
                    bundle.alu_src   = 1'b1;
                    bundle.mem_write = 1'b1;
                    bundle.alu_op    = ALU_ADD;
                    bundle.imm       = imm_d;
                end
                default: bundle.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/sign_extend.sv
// rtl/sign_extend.sv - replicate the field MSB up to OUT_W bits
module sign_extend #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 64
) (
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out
);

    assign out = {{(OUT_W-IN_W){in[IN_W-1]}}, in};

endmodule

// File: rtl/legv8_decode_stage.sv
// rtl/legv8_decode_stage.sv - decode pipeline stage with 2-entry skid buffer and illegal counter
module legv8_decode_stage
    import legv8_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              reg2loc,
    output logic              alu_src,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              mem_write,
    output logic              mem_read,
    output logic              br_cond,
    output logic              br_uncond,
    output logic [2:0]        alu_op,
    output logic [4:0]        rd,
    output logic [4:0]        rn,
    output logic [4:0]        rm,
    output logic [DATA_W-1:0] imm,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    ctrl_bundle_t dec;
    ctrl_bundle_t out_q;
    ctrl_bundle_t skid_q;
    logic         out_valid_q;
    logic         skid_valid_q;
    logic         in_ready_q;
    logic [CNT_W-1:0] cnt_q;

    logic in_xfer;
    logic out_xfer;
    logic out_free;

    legv8_decoder u_decoder (.instr(instr), .bundle(dec));

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_xfer;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            cnt_q        <= '0;
        end else begin
            if (in_xfer && dec.illegal && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + 1'b1;

            if (flush) begin
                out_valid_q  <= 1'b0;
                skid_valid_q <= 1'b0;
                in_ready_q   <= 1'b1;
            end else if (out_free) begin
                // Skid can only be occupied while the head is, so in_xfer is 0 here.
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= 1'b0;
                    in_ready_q   <= 1'b1;
                end else begin
                    if (in_xfer)
                        out_q <= dec;
                    out_valid_q <= in_xfer;
                    in_ready_q  <= 1'b1;
                end
            end else if (in_xfer) begin
                skid_q       <= dec;
                skid_valid_q <= 1'b1;
                in_ready_q   <= 1'b0;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign reg2loc     = out_q.reg2loc;
    assign alu_src     = out_q.alu_src;
    assign mem_to_reg  = out_q.mem_to_reg;
    assign reg_write   = out_q.reg_write;
    assign mem_write   = out_q.mem_write;
    assign mem_read    = out_q.mem_read;
    assign br_cond     = out_q.br_cond;
    assign br_uncond   = out_q.br_uncond;
    assign alu_op      = out_q.alu_op;
    assign rd          = out_q.rd;
    assign rn          = out_q.rn;
    assign rm          = out_q.rm;
    assign imm         = out_q.imm[DATA_W-1:0];
    assign illegal     = out_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_legv8_decode_stage.sv
// tb/tb_legv8_decode_stage.sv - directed self-checking bench for legv8_decode_stage
module tb_legv8_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr;
    logic        reg2loc, alu_src, mem_to_reg, reg_write, mem_write, mem_read, br_cond, br_uncond;
    logic [2:0]  alu_op;
    logic [4:0]  rd, rn, rm;
    logic [63:0] imm;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    legv8_decode_stage #(.DATA_W(64), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .reg2loc(reg2loc), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .mem_write(mem_write), .mem_read(mem_read), .br_cond(br_cond), .br_uncond(br_uncond),
        .alu_op(alu_op), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .illegal(illegal),
        .illegal_cnt(illegal_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] add_rd(input logic [4:0] r);
        return {11'b10001011000, 5'd0, 6'd0, 5'd0, r};
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = '0;
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_cnt", illegal_cnt, 0);
        check("rst_imm", imm, 0);
        check("rst_ctrl", {reg2loc, alu_src, reg_write, mem_read, br_cond, rd}, 0);
        rst_n = 1'b1;

        // Streaming with out_ready=1: every cycle replaces the head, no bubbles.
        in_valid = 1'b1; instr = 32'h8B020023;
        tick();
        check("add_valid", out_valid, 1);
        check("add_ctrl", {reg2loc, alu_src, mem_to_reg, reg_write, mem_write, mem_read, br_cond, br_uncond}, 8'b1001_0000);
        check("add_aluop", alu_op, 3'b010);
        check("add_regs", {rd, rn, rm}, {5'd3, 5'd1, 5'd2});
        check("add_illegal", illegal, 0);
        instr = 32'hF85F80C5;
        tick();
        check("ldur_valid", out_valid, 1);
        check("ldur_ctrl", {reg2loc, alu_src, mem_to_reg, reg_write, mem_write, mem_read, br_cond, br_uncond}, 8'b0111_0100);
        check("ldur_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ldur_regs", {rd, rn}, {5'd5, 5'd6});
        instr = 32'hB4FFFFC4;
        tick();
        check("cbz_ctrl", {reg2loc, alu_src, reg_write, br_cond, br_uncond}, 5'b00010);
        check("cbz_aluop", alu_op, 3'b000);
        check("cbz_imm", imm, 64'hFFFF_FFFF_FFFF_FFFE);
        check("cbz_rd", rd, 4);
        instr = 32'h14000003;
        tick();
        check("b_ctrl", {br_cond, br_uncond, reg_write}, 3'b010);
        check("b_imm", imm, 3);
        instr = {10'b1001000100, 12'hFFF, 5'd2, 5'd1};
        tick();
        check("addi_ctrl", {reg2loc, alu_src, reg_write, mem_read}, 4'b0110);
        check("addi_imm_zext", imm, 64'h0000_0000_0000_0FFF);
        check("addi_aluop", alu_op, 3'b010);
        instr = {11'b11001011000, 5'd7, 6'd0, 5'd8, 5'd9};
        tick();
        check("sub_aluop", alu_op, 3'b011);
        check("sub_regs", {reg2loc, reg_write, rd, rn, rm}, {2'b11, 5'd9, 5'd8, 5'd7});
        instr = {11'b11111000000, 9'h100, 2'b00, 5'd10, 5'd11};
        tick();
        check("stur_ctrl", {reg2loc, alu_src, mem_to_reg, reg_write, mem_write, mem_read}, 6'b010010);
        check("stur_imm", imm, 64'hFFFF_FFFF_FFFF_FF00);
        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 0);

        // Backpressure: A held, B in skid, C refused until space frees.
        out_ready = 1'b0; in_valid = 1'b1; instr = add_rd(5'd1);
        tick();
        check("bp_a_valid", out_valid, 1);
        check("bp_ready_1", in_ready, 1);
        instr = add_rd(5'd2);
        tick();
        check("bp_a_held", rd, 1);
        check("bp_ready_0", in_ready, 0);
        instr = add_rd(5'd3);
        tick();
        check("bp_still_a", {out_valid, rd}, {1'b1, 5'd1});
        check("bp_c_refused", in_ready, 0);
        out_ready = 1'b1;
        tick();
        check("bp_b_out", {out_valid, rd}, {1'b1, 5'd2});
        check("bp_ready_back", in_ready, 1);
        tick();
        check("bp_c_out", {out_valid, rd}, {1'b1, 5'd3});
        in_valid = 1'b0;
        tick();
        check("bp_empty", out_valid, 0);

        // Illegal words: counter saturates at 255.
        check("cnt_before", illegal_cnt, 0);
        in_valid = 1'b1; instr = 32'h0000_0000;
        tick();
        check("ill_flag", illegal, 1);
        check("ill_ctrl", {reg_write, mem_write, mem_read, br_cond, br_uncond}, 0);
        check("ill_imm", imm, 0);
        check("ill_cnt_1", illegal_cnt, 1);
        for (int i = 2; i <= 300; i++) begin
            tick();
            if (i == 254) check("ill_cnt_254", illegal_cnt, 254);
            if (i == 255) check("ill_cnt_255", illegal_cnt, 255);
        end
        check("ill_cnt_sat", illegal_cnt, 255);

        // Flush with both entries full and in_valid asserted.
        out_ready = 1'b0; instr = add_rd(5'd4);
        tick();
        instr = add_rd(5'd5);
        tick();
        check("fl_full", in_ready, 0);
        flush = 1'b1; instr = add_rd(5'd6);
        tick();
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("fl_no_stale", out_valid, 0);
        check("fl_cnt_kept", illegal_cnt, 255);

        // Same scenario but with reset instead of flush.
        out_ready = 1'b0; in_valid = 1'b1; instr = add_rd(5'd7);
        tick();
        instr = add_rd(5'd8);
        tick();
        check("rs_full", in_ready, 0);
        rst_n = 1'b0; flush = 1'b1;
        tick();
        check("rs_valid", out_valid, 0);
        check("rs_ready", in_ready, 1);
        check("rs_cnt", illegal_cnt, 0);
        check("rs_fields", {reg2loc, reg_write, alu_op, rd, rn, rm, illegal}, 0);
        check("rs_imm", imm, 0);
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("rs_no_stale", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
